vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
//
// Recovers pixel coordinates from an incoming VGA stream (hsync/vsync plus
// 8-bit RGB 3:3:2). It measures line and frame timing and locks after
// LOCK_FRAMES consecutive clean frames. While locked, it emits each active
// pixel with its coordinates and captured colour.
//
// Pipeline:
//   stage 1 : every input pin is registered once on dclk.
//   stage 2 : the counters, timing checks and FSM next state are evaluated
//             combinationally from the stage-1 sample. All outputs are then
//             registered. This gives exactly 2 dclk of latency from the pins
//             to the outputs.
//
// Ports:
//   dclk, clr_n          pixel clock; asynchronous active-low reset
//   hsync, vsync         active-low sync inputs
//   red, green, blue     incoming colour (3/3/2 bits)
//   pix_valid            active-video pixel present on the outputs
//   pix_x, pix_y         pixel column (0..639) and line (0..479)
//   pix_r, pix_g, pix_b  captured colour; zero when pix_valid is low
//   frame_start          one-cycle pulse on pixel (0,0)
//   locked               timing lock achieved
//   timing_err           one-cycle pulse per violation, only while acquiring
//                        or locked
//   dbg_state            current FSM state (0 SEARCH, 1 ACQUIRE, 2 LOCKED)
// -----------------------------------------------------------------------------
module vga_sync_decoder #(
    parameter int HPIXELS     = 800,
    parameter int VLINES      = 521,
    parameter int HPULSE      = 96,
    parameter int VPULSE      = 2,
    parameter int HBP         = 144,
    parameter int HFP         = 784,
    parameter int VBP         = 31,
    parameter int VFP         = 511,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       dclk,
    input  logic       clr_n,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] red,
    input  logic [2:0] green,
    input  logic [1:0] blue,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic [2:0] pix_r,
    output logic [2:0] pix_g,
    output logic [1:0] pix_b,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_err,
    output logic [1:0] dbg_state
);

    localparam logic [9:0] CNT_MAX = 10'd1023;
    localparam logic [9:0] H_LAST  = 10'(HPIXELS - 1);
    localparam logic [9:0] V_LAST  = 10'(VLINES - 1);
    localparam logic [9:0] H_PW    = 10'(HPULSE);
    localparam logic [9:0] V_PW    = 10'(VPULSE);
    localparam logic [9:0] H_BP    = 10'(HBP);
    localparam logic [9:0] H_FP    = 10'(HFP);
    localparam logic [9:0] V_BP    = 10'(VBP);
    localparam logic [9:0] V_FP    = 10'(VFP);

    localparam int               LCW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [LCW-1:0]   LOCK_N    = LCW'(LOCK_FRAMES);
    localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // ---------------------------------------------------------------- stage 1
    logic       hs_q, vs_q;
    logic [2:0] red_q, green_q;
    logic [1:0] blue_q;

    // Previous stage-1 sample. It is used for edge detection on the
    // registered stream. It resets to the idle-high level, so a stream that
    // starts low right after reset still counts as a falling edge.
    logic       hs_prev_q, vs_prev_q;

    // ------------------------------------------------------ measurement state
    logic [9:0]     hc_q, hc_d;            // hc of the previous sample
    logic [9:0]     vc_q, vc_d;
    logic [9:0]     hrise_hc_q, hrise_hc_d;  // hc where hsync last rose
    logic [9:0]     vrise_vc_q, vrise_vc_d;  // vc where vsync last rose
    logic           hfall_seen_q, hfall_seen_d;
    logic           vfall_seen_q, vfall_seen_d;
    logic           vfall_pend_q, vfall_pend_d;  // vsync fell, no hsync fall yet
    state_t         state_q, state_d;
    logic [LCW-1:0] good_cnt_q, good_cnt_d;

    // ---------------------------------------------------------- output flops
    logic       pix_valid_q, pix_valid_d;
    logic [9:0] pix_x_q, pix_x_d;
    logic [8:0] pix_y_q, pix_y_d;
    logic [2:0] pix_r_q, pix_r_d;
    logic [2:0] pix_g_q, pix_g_d;
    logic [1:0] pix_b_q, pix_b_d;
    logic       frame_start_q, frame_start_d;
    logic       locked_q, locked_d;
    logic       timing_err_q, timing_err_d;

    // --------------------------------------------------- combinational helpers
    logic       h_fall, h_rise, v_fall, v_rise;
    logic       line_viol, frame_viol, timeout, viol;
    logic       in_win;
    logic [9:0] px;
    logic [8:0] py;

    // Edge detection and position of the current stage-1 sample.
    always_comb begin
        h_fall = hs_prev_q & ~hs_q;
        h_rise = ~hs_prev_q & hs_q;
        v_fall = vs_prev_q & ~vs_q;
        v_rise = ~vs_prev_q & vs_q;

        hc_d = (hc_q == CNT_MAX) ? CNT_MAX : hc_q + 10'd1;
        if (h_fall) begin
            hc_d = 10'd0;
        end

        // vc moves only at line starts. A vsync fall anywhere since the
        // previous line start, or in this same cycle, restarts the frame.
        vc_d = vc_q;
        if (h_fall) begin
            if (v_fall || vfall_pend_q) begin
                vc_d = 10'd0;
            end else begin
                vc_d = (vc_q == CNT_MAX) ? CNT_MAX : vc_q + 10'd1;
            end
        end

        vfall_pend_d = h_fall ? 1'b0 : (vfall_pend_q | v_fall);
        hrise_hc_d   = h_rise ? hc_d : hrise_hc_q;
        vrise_vc_d   = v_rise ? vc_d : vrise_vc_q;
        hfall_seen_d = hfall_seen_q | h_fall;
        vfall_seen_d = vfall_seen_q | v_fall;
    end

    // Timing checks. At a line start, hc_q still holds the last column of
    // the line that just ended. At a frame start, vc_q still holds the last
    // line of the frame that just ended.
    always_comb begin
        line_viol  = h_fall && hfall_seen_q &&
                     ((hc_q != H_LAST) || (hrise_hc_q != H_PW));
        frame_viol = v_fall && vfall_seen_q &&
                     ((vc_q != V_LAST) || (vrise_vc_q != V_PW));
        // Only the arrival at saturation counts, so a stalled stream
        // reports once rather than on every cycle.
        timeout    = ((hc_d == CNT_MAX) && (hc_q != CNT_MAX)) ||
                     ((vc_d == CNT_MAX) && (vc_q != CNT_MAX));
        viol       = line_viol | frame_viol | timeout;
    end

    // FSM next state.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        case (state_q)
            ST_SEARCH: begin
                // Violations are ignored here. The first frame edge always
                // starts acquisition.
                if (v_fall) begin
                    state_d    = ST_ACQUIRE;
                    good_cnt_d = '0;
                end
            end
            ST_ACQUIRE: begin
                if (viol) begin
                    state_d = ST_SEARCH;
                end else if (v_fall) begin
                    if (good_cnt_q == LOCK_LAST) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = LOCK_N;
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (viol) begin
                    state_d = ST_SEARCH;
                end
            end
            default: begin
                state_d    = ST_SEARCH;
                good_cnt_d = '0;
            end
        endcase
    end

    // Output stage. The outputs use the next state, so a violating sample
    // already shows locked=0 and pix_valid=0, and the sample that completes
    // lock is already reported as locked.
    always_comb begin
        in_win = (hc_d >= H_BP) && (hc_d < H_FP) &&
                 (vc_d >= V_BP) && (vc_d < V_FP);
        px     = hc_d - H_BP;
        py     = 9'(vc_d - V_BP);

        pix_valid_d   = (state_d == ST_LOCKED) && in_win;
        pix_x_d       = '0;
        pix_y_d       = '0;
        pix_r_d       = '0;
        pix_g_d       = '0;
        pix_b_d       = '0;
        if (pix_valid_d) begin
            pix_x_d = px;
            pix_y_d = py;
            pix_r_d = red_q;
            pix_g_d = green_q;
            pix_b_d = blue_q;
        end
        frame_start_d = pix_valid_d && (px == 10'd0) && (py == 9'd0);
        locked_d      = (state_d == ST_LOCKED);
        timing_err_d  = viol && (state_q != ST_SEARCH);
    end

    // ---------------------------------------------------------------- flops
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hc_q          <= '0;
            vc_q          <= '0;
            hrise_hc_q    <= '0;
            vrise_vc_q    <= '0;
            hfall_seen_q  <= 1'b0;
            vfall_seen_q  <= 1'b0;
            vfall_pend_q  <= 1'b0;
            state_q       <= ST_SEARCH;
            good_cnt_q    <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_r_q       <= '0;
            pix_g_q       <= '0;
            pix_b_q       <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            timing_err_q  <= 1'b0;
        end else begin
            hs_q          <= hsync;
            vs_q          <= vsync;
            hs_prev_q     <= hs_q;
            vs_prev_q     <= vs_q;
            red_q         <= red;
            green_q       <= green;
            blue_q        <= blue;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hrise_hc_q    <= hrise_hc_d;
            vrise_vc_q    <= vrise_vc_d;
            hfall_seen_q  <= hfall_seen_d;
            vfall_seen_q  <= vfall_seen_d;
            vfall_pend_q  <= vfall_pend_d;
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_r_q       <= pix_r_d;
            pix_g_q       <= pix_g_d;
            pix_b_q       <= pix_b_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            timing_err_q  <= timing_err_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_r       = pix_r_q;
    assign pix_g       = pix_g_q;
    assign pix_b       = pix_b_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign timing_err  = timing_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Directed bench on a scaled-down raster: 40 clocks per line and 20 lines per
// frame. The active window is 24x14 pixels (columns 8..31, lines 3..16),
// which keeps each frame to 800 cycles.
//
// Each driven sample pushes its expected output word onto exp_q. The word
// popped two clocks later is compared with the DUT outputs. The transmitter
// coordinates set the expected window, coordinates and colour. The script
// sets the expected lock level and any error pulse at the samples where
// they occur.
// -----------------------------------------------------------------------------
module tb_vga_sync_decoder;

    localparam int HPIXELS     = 40;
    localparam int VLINES      = 20;
    localparam int HPULSE      = 4;
    localparam int VPULSE      = 2;
    localparam int HBP         = 8;
    localparam int HFP         = 32;
    localparam int VBP         = 3;
    localparam int VFP         = 17;
    localparam int LOCK_FRAMES = 2;
    localparam int W           = 32;

    // -------------------------------------------------------- clock / reset
    logic       dclk  = 1'b0;
    logic       clr_n = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [2:0] red   = '0;
    logic [2:0] green = '0;
    logic [1:0] blue  = '0;

    logic       pix_valid, frame_start, locked, timing_err;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [2:0] pix_r, pix_g;
    logic [1:0] pix_b;
    logic [1:0] dbg_state;

    always #20 dclk = ~dclk;

    vga_sync_decoder #(
        .HPIXELS(HPIXELS), .VLINES(VLINES), .HPULSE(HPULSE), .VPULSE(VPULSE),
        .HBP(HBP), .HFP(HFP), .VBP(VBP), .VFP(VFP), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .dclk(dclk), .clr_n(clr_n), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
        .dbg_state(dbg_state)
    );

    // ------------------------------------------------------------ scoreboard
    logic [W-1:0] exp_q[$];
    int total     = 0;
    int bad       = 0;
    int valid_cnt = 0;
    int fs_cnt    = 0;
    int err_cnt   = 0;
    bit exp_lk    = 1'b0;

    function automatic logic [W-1:0] obs_vec();
        return {1'b0, timing_err, locked, frame_start, pix_valid,
                pix_x, pix_y, pix_r, pix_g, pix_b};
    endfunction

    function automatic logic [W-1:0] exp_vec(input int h, input int v,
                                             input bit lk, input bit e);
        logic       vld;
        logic [9:0] x, hv, vv;
        logic [8:0] y;
        logic [2:0] r, g;
        logic [1:0] b;
        hv  = 10'(h);
        vv  = 10'(v);
        vld = lk && (h >= HBP) && (h < HFP) && (v >= VBP) && (v < VFP);
        x = '0; y = '0; r = '0; g = '0; b = '0;
        if (vld) begin
            x = 10'(h - HBP);
            y = 9'(v - VBP);
            r = hv[2:0];
            g = vv[2:0];
            b = hv[4:3];
        end
        return {1'b0, e, lk, vld && (x == 10'd0) && (y == 9'd0), vld,
                x, y, r, g, b};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // --------------------------------------------------------------- drivers
    // One clock: check the output for the sample driven two clocks ago,
    // then drive the next sample and queue its expectation.
    task automatic send(input logic hs, input logic vs, input int h,
                        input int v, input bit e);
        logic [9:0] hv, vv;
        @(posedge dclk);
        #1;
        if (exp_q.size() == 2) begin
            chk("pipe", obs_vec(), exp_q.pop_front());
            valid_cnt += int'(pix_valid);
            fs_cnt    += int'(frame_start);
            err_cnt   += int'(timing_err);
        end
        hv    = 10'(h);
        vv    = 10'(v);
        hsync = hs;
        vsync = vs;
        red   = hv[2:0];
        green = vv[2:0];
        blue  = hv[4:3];
        exp_q.push_back(exp_vec(h, v, exp_lk, e));
    endtask

    // One frame of standard timing with optional faults:
    //   lk_start/err_start : expected lock level and error pulse at pixel (0,0)
    //   short_line         : this line is one clock short
    //   err_line           : error expected at the start of this line
    //   vlow               : vsync low width in lines
    //   n_lines            : lines actually sent
    task automatic drive_frame(input bit lk_start, input bit err_start,
                               input int short_line, input int err_line,
                               input int vlow, input int n_lines);
        for (int v = 0; v < n_lines; v++) begin
            int len;
            len = (v == short_line) ? HPIXELS - 1 : HPIXELS;
            for (int h = 0; h < len; h++) begin
                bit e;
                e = 1'b0;
                if (v == 0 && h == 0) begin
                    exp_lk = lk_start;
                    e      = err_start;
                end
                if (v == err_line && h == 0) begin
                    exp_lk = 1'b0;
                    e      = 1'b1;
                end
                send((h < HPULSE) ? 1'b0 : 1'b1, (v < vlow) ? 1'b0 : 1'b1,
                     h, v, e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b1, 1'b1, 0, 0, 1'b0);
    endtask

    // Asserts clr_n for n clocks. Outputs must be zero at once and stay zero.
    task automatic reset_pulse(input int n);
        exp_q.delete();
        clr_n = 1'b0;
        #1;
        chk("rst_out", obs_vec(), '0);
        for (int i = 0; i < n; i++) begin
            @(posedge dclk);
            #1;
            chk("rst_out", obs_vec(), '0);
            chk("rst_state", 32'(dbg_state), 32'd0);
        end
        clr_n = 1'b1;
    endtask

    // -------------------------------------------------------------- sequence
    initial begin
        // Power-up reset: outputs zero, FSM in SEARCH.
        for (int i = 0; i < 4; i++) begin
            red = 3'($urandom_range(0, 7));
            @(posedge dclk);
            #1;
            chk("por_out", obs_vec(), '0);
            chk("por_state", 32'(dbg_state), 32'd0);
        end
        clr_n = 1'b1;
        idle(5);

        // Lock: frames 1 and 2 acquire; lock rises at the start of frame 3.
        drive_frame(1'b0, 1'b0, -1, -1, VPULSE, VLINES);
        drive_frame(1'b0, 1'b0, -1, -1, VPULSE, VLINES);
        valid_cnt = 0; fs_cnt = 0;
        drive_frame(1'b1, 1'b0, -1, -1, VPULSE, VLINES);
        chk("f3_valid_cnt", 32'(valid_cnt), 32'd336);
        chk("f3_fs_cnt", 32'(fs_cnt), 32'd1);

        // Line 5 is one clock short; the error is flagged at the start of line 6.
        valid_cnt = 0; err_cnt = 0;
        drive_frame(1'b1, 1'b0, 5, 6, VPULSE, VLINES);
        drive_frame(1'b0, 1'b0, -1, -1, VPULSE, VLINES);
        drive_frame(1'b0, 1'b0, -1, -1, VPULSE, VLINES);
        chk("len_err_cnt", 32'(err_cnt), 32'd1);
        chk("len_valid_cnt", 32'(valid_cnt), 32'd72);

        // vsync held low for 3 lines; flagged at the next frame start.
        err_cnt = 0;
        drive_frame(1'b1, 1'b0, -1, -1, 3, VLINES);
        drive_frame(1'b0, 1'b1, -1, -1, VPULSE, VLINES);
        chk("vw_err_cnt", 32'(err_cnt), 32'd1);
        drive_frame(1'b0, 1'b0, -1, -1, VPULSE, VLINES);
        drive_frame(1'b0, 1'b0, -1, -1, VPULSE, VLINES);
        drive_frame(1'b1, 1'b0, -1, -1, VPULSE, VLINES);

        // Timeout: hsync held high. The column continues from 40 and
        // reaches 1023 on hold sample 983.
        err_cnt = 0;
        for (int k = 0; k < 1100; k++) begin
            bit e;
            e = ((40 + k) == 1023);
            if (e) exp_lk = 1'b0;
            send(1'b1, 1'b1, 40 + k, VLINES - 1, e);
        end
        chk("to_err_cnt", 32'(err_cnt), 32'd1);
        chk("to_state", 32'(dbg_state), 32'd0);

        // Relock, then reset for 3 clocks in the middle of a locked frame.
        drive_frame(1'b0, 1'b0, -1, -1, VPULSE, VLINES);
        drive_frame(1'b0, 1'b0, -1, -1, VPULSE, VLINES);
        drive_frame(1'b1, 1'b0, -1, -1, VPULSE, 8);
        chk("pre_rst_lock", 32'(locked), 32'd1);
        reset_pulse(3);
        exp_lk = 1'b0;
        err_cnt = 0; valid_cnt = 0; fs_cnt = 0;
        idle(5);
        drive_frame(1'b0, 1'b0, -1, -1, VPULSE, VLINES);
        drive_frame(1'b0, 1'b0, -1, -1, VPULSE, VLINES);
        drive_frame(1'b1, 1'b0, -1, -1, VPULSE, VLINES);
        send(1'b1, 1'b1, HPIXELS, VLINES - 1, 1'b0);
        send(1'b1, 1'b1, HPIXELS + 1, VLINES - 1, 1'b0);
        send(1'b1, 1'b1, HPIXELS + 2, VLINES - 1, 1'b0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("relock_valid_cnt", 32'(valid_cnt), 32'd336);
        chk("relock_fs_cnt", 32'(fs_cnt), 32'd1);
        chk("relock_state", 32'(dbg_state), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
